// File: rtl/cv_tmds_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cv_tmds_pkg
// Description : Shared TMDS symbol width, control/guard-band symbols and
//               bit-phase constants for the cv_tmds serializer slice.
// Revision    : 1.0 - initial release
// ============================================================================
package cv_tmds_pkg;

    localparam int SYM_W = 10;
    typedef logic [SYM_W-1:0] sym_t;

    // TMDS control symbols, indexed by {C1,C0}
    localparam sym_t CTRL_00 = 10'b1101010100;
    localparam sym_t CTRL_01 = 10'b0010101011;
    localparam sym_t CTRL_10 = 10'b0101010100;
    localparam sym_t CTRL_11 = 10'b1010101011;

    localparam sym_t CLK_PATTERN = 10'b1111100000;

    localparam sym_t VGB_RB = 10'b1011001100;
    localparam sym_t VGB_G  = 10'b0100110011;
    localparam sym_t DIGB   = 10'b0100110011;

    localparam int             PH_W    = 4;
    localparam logic [PH_W-1:0] PH_LAST = 4'd9;

    function automatic sym_t ctrl_sym(input logic [1:0] c);
        sym_t s;
        case (c)
            2'b00:   s = CTRL_00;
            2'b01:   s = CTRL_01;
            2'b10:   s = CTRL_10;
            default: s = CTRL_11;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cv_tmds_shift10.sv
`default_nettype none
// ============================================================================
// Module      : cv_tmds_shift10
// Description : 10-bit load/shift register presenting one TMDS bit per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module cv_tmds_shift10
    import cv_tmds_pkg::*;
#(
    parameter bit   LSB_FIRST = 1'b1,
    parameter sym_t RST_VAL   = CTRL_00
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  sym_t din,
    output logic dout
);

    sym_t r_sh;
    sym_t w_shifted;

    // Vacated bits are never transmitted before the next load
    generate
        if (LSB_FIRST) begin : g_lsb
            assign w_shifted = {1'b0, r_sh[SYM_W-1:1]};
            assign dout      = r_sh[0];
        end else begin : g_msb
            assign w_shifted = {r_sh[SYM_W-2:0], 1'b0};
            assign dout      = r_sh[SYM_W-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sh <= RST_VAL;
        end else if (load) begin
            r_sh <= din;
        end else begin
            r_sh <= w_shifted;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cv_tmds_serializer.sv
`default_nettype none
// ============================================================================
// Module      : cv_tmds_serializer
// Description : Bit-clock TMDS serializer for R/G/B plus clock channel, with
//               idle-symbol insertion and sticky underrun detection.
// Revision    : 1.0 - initial release
// ============================================================================
module cv_tmds_serializer
    import cv_tmds_pkg::*;
#(
    parameter int   LSB_FIRST   = 1,
    parameter sym_t IDLE_SYM    = cv_tmds_pkg::CTRL_00,
    parameter sym_t CLK_PATTERN = cv_tmds_pkg::CLK_PATTERN
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            sym_valid,
    output logic            sym_ready,
    input  sym_t            sym_r,
    input  sym_t            sym_g,
    input  sym_t            sym_b,
    output logic            ser_r,
    output logic            ser_g,
    output logic            ser_b,
    output logic            ser_clk,
    output logic [PH_W-1:0] phase,
    output logic            underrun,
    input  logic            underrun_clr
);

    localparam bit c_lsb_first = (LSB_FIRST != 0);

    logic [PH_W-1:0] r_phase;
    logic            r_ready;
    logic            r_primed;
    logic            r_underrun;

    logic [PH_W-1:0] w_phase_nxt;
    logic            w_load;
    logic            w_underrun_set;
    sym_t            w_din_r;
    sym_t            w_din_g;
    sym_t            w_din_b;

    assign w_load      = (r_phase == PH_LAST);
    assign w_phase_nxt = w_load ? '0 : r_phase + 1'b1;

    // Underrun only counts once a real symbol has been accepted
    assign w_underrun_set = w_load && !sym_valid && r_primed;

    assign w_din_r = sym_valid ? sym_r : IDLE_SYM;
    assign w_din_g = sym_valid ? sym_g : IDLE_SYM;
    assign w_din_b = sym_valid ? sym_b : IDLE_SYM;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_phase <= '0;
            r_ready <= 1'b0;
        end else begin
            r_phase <= w_phase_nxt;
            r_ready <= (w_phase_nxt == PH_LAST);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_primed   <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (w_load && sym_valid) begin
                r_primed <= 1'b1;
            end
            if (w_underrun_set) begin
                r_underrun <= 1'b1;
            end else if (underrun_clr) begin
                r_underrun <= 1'b0;
            end
        end
    end

    cv_tmds_shift10 #(
        .LSB_FIRST (c_lsb_first),
        .RST_VAL   (IDLE_SYM)
    ) u_shift_r (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (w_load),
        .din     (w_din_r),
        .dout    (ser_r)
    );

    cv_tmds_shift10 #(
        .LSB_FIRST (c_lsb_first),
        .RST_VAL   (IDLE_SYM)
    ) u_shift_g (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (w_load),
        .din     (w_din_g),
        .dout    (ser_g)
    );

    cv_tmds_shift10 #(
        .LSB_FIRST (c_lsb_first),
        .RST_VAL   (IDLE_SYM)
    ) u_shift_b (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (w_load),
        .din     (w_din_b),
        .dout    (ser_b)
    );

    cv_tmds_shift10 #(
        .LSB_FIRST (c_lsb_first),
        .RST_VAL   (CLK_PATTERN)
    ) u_shift_clk (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (w_load),
        .din     (CLK_PATTERN),
        .dout    (ser_clk)
    );

    assign phase     = r_phase;
    assign sym_ready = r_ready;
    assign underrun  = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_cv_tmds_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cv_tmds_serializer
// Description : Directed, table-driven bench for cv_tmds_serializer (LSB- and
//               MSB-first instances driven in lockstep).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cv_tmds_serializer;

    localparam logic [9:0] IDLE = 10'b1101010100;
    localparam logic [9:0] CLKP = 10'b1111100000;

    logic       clk          = 1'b0;
    logic       reset_n      = 1'b0;
    logic       sym_valid    = 1'b0;
    logic       underrun_clr = 1'b0;
    logic [9:0] sym_r        = '0;
    logic [9:0] sym_g        = '0;
    logic [9:0] sym_b        = '0;

    logic       sym_ready, ser_r, ser_g, ser_b, ser_clk, underrun;
    logic [3:0] phase;
    logic       m_ready, m_r, m_g, m_b, m_clk, m_under;
    logic [3:0] m_phase;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic       v;
        logic       clr;
        logic [9:0] r, g, b;
        logic [9:0] er, eg, eb;
        logic       eu;
    } vec_t;

    vec_t tbl[10];

    cv_tmds_serializer #(.LSB_FIRST(1)) dut (
        .clk(clk), .reset_n(reset_n), .sym_valid(sym_valid), .sym_ready(sym_ready),
        .sym_r(sym_r), .sym_g(sym_g), .sym_b(sym_b),
        .ser_r(ser_r), .ser_g(ser_g), .ser_b(ser_b), .ser_clk(ser_clk),
        .phase(phase), .underrun(underrun), .underrun_clr(underrun_clr)
    );

    cv_tmds_serializer #(.LSB_FIRST(0)) dut_m (
        .clk(clk), .reset_n(reset_n), .sym_valid(sym_valid), .sym_ready(m_ready),
        .sym_r(sym_r), .sym_g(sym_g), .sym_b(sym_b),
        .ser_r(m_r), .ser_g(m_g), .ser_b(m_b), .ser_clk(m_clk),
        .phase(m_phase), .underrun(m_under), .underrun_clr(underrun_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] rev10(input logic [9:0] x);
        logic [9:0] o;
        for (int i = 0; i < 10; i++) o[i] = x[9-i];
        return o;
    endfunction

    function automatic vec_t mk(input logic v, input logic clr, input logic [9:0] r,
                                input logic [9:0] g, input logic [9:0] b, input logic eu);
        vec_t t;
        t.v = v; t.clr = clr; t.r = r; t.g = g; t.b = b;
        t.er = v ? r : IDLE;
        t.eg = v ? g : IDLE;
        t.eb = v ? b : IDLE;
        t.eu = eu;
        return t;
    endfunction

    task automatic wait_phase(input logic [3:0] p, input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (phase == p) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) chk(nm, 32'd0, 32'd1);
    endtask

    initial begin
        logic [9:0] cr, cg, cb, cc, crdy, cmb, cmc;
        logic       ph_ok;
        int         n;

        tbl[0] = mk(1'b0, 1'b0, 10'h3FF, 10'h000, 10'h155, 1'b0);
        tbl[1] = mk(1'b0, 1'b0, 10'h2CC, 10'h2CC, 10'h2CC, 1'b0);
        tbl[2] = mk(1'b1, 1'b0, 10'h2CC, 10'h155, 10'h0F0, 1'b0);
        tbl[3] = mk(1'b1, 1'b0, 10'h3FF, 10'h000, 10'h201, 1'b0);
        tbl[4] = mk(1'b0, 1'b0, 10'h111, 10'h222, 10'h333, 1'b1);
        tbl[5] = mk(1'b0, 1'b1, 10'h111, 10'h222, 10'h333, 1'b1);
        tbl[6] = mk(1'b1, 1'b1, 10'h123, 10'h2AA, 10'h3E0, 1'b0);
        tbl[7] = mk(1'b1, 1'b0, 10'h001, 10'h200, 10'h18C, 1'b0);
        tbl[8] = mk(1'b0, 1'b1, 10'h0AB, 10'h0CD, 10'h0EF, 1'b1);
        tbl[9] = mk(1'b1, 1'b0, 10'h0AB, 10'h354, 10'h3E0, 1'b1);

        // Reset state
        repeat (3) tick();
        chk("rst_ser_r", ser_r, 0);
        chk("rst_ser_g", ser_g, 0);
        chk("rst_ser_b", ser_b, 0);
        chk("rst_ser_clk", ser_clk, 0);
        chk("rst_phase", phase, 0);
        chk("rst_ready", sym_ready, 0);
        chk("rst_underrun", underrun, 0);
        #2 reset_n = 1'b1;
        #1;
        n = 0;
        while (!sym_ready && n < 20) begin
            tick();
            n++;
        end
        // Visible after the 9th edge, i.e. during the 10th cycle at phase 9
        chk("first_ready_edges", n, 9);
        chk("first_ready_phase", phase, 9);

        for (int i = 0; i < 10; i++) begin
            wait_phase(4'd9, "timeout_phase9");
            sym_valid    = tbl[i].v;
            underrun_clr = tbl[i].clr;
            sym_r        = tbl[i].r;
            sym_g        = tbl[i].g;
            sym_b        = tbl[i].b;
            tick();
            underrun_clr = 1'b0;
            chk($sformatf("v%0d_underrun", i), underrun, tbl[i].eu);
            chk($sformatf("v%0d_m_underrun", i), m_under, tbl[i].eu);
            ph_ok = 1'b1;
            for (int k = 0; k < 10; k++) begin
                cr[k] = ser_r; cg[k] = ser_g; cb[k] = ser_b; cc[k] = ser_clk;
                crdy[k] = sym_ready; cmb[k] = m_b; cmc[k] = m_clk;
                if (phase != k[3:0]) ph_ok = 1'b0;
                if (k < 9) tick();
            end
            chk($sformatf("v%0d_ser_r", i), cr, tbl[i].er);
            chk($sformatf("v%0d_ser_g", i), cg, tbl[i].eg);
            chk($sformatf("v%0d_ser_b", i), cb, tbl[i].eb);
            chk($sformatf("v%0d_ser_clk", i), cc, CLKP);
            chk($sformatf("v%0d_ready", i), crdy, 10'b10_0000_0000);
            chk($sformatf("v%0d_phase_seq", i), ph_ok, 1'b1);
            chk($sformatf("v%0d_msb_ser_b", i), cmb, rev10(tbl[i].eb));
            chk($sformatf("v%0d_msb_ser_clk", i), cmc, 10'b00000_11111);
        end

        // Hand-computed MSB-first check: 3E0 sent as 1,1,1,1,1,0,0,0,0,0
        wait_phase(4'd9, "timeout_msb");
        sym_valid = 1'b1;
        sym_b     = 10'h3E0;
        tick();
        for (int k = 0; k < 10; k++) begin
            cmb[k] = m_b;
            if (k < 9) tick();
        end
        chk("msb_3e0_stream", cmb, 10'b00000_11111);

        // Reset asserted mid-symbol; underrun is 1 here and must clear
        sym_valid = 1'b0;
        wait_phase(4'd4, "timeout_phase4");
        reset_n = 1'b0;
        #1;
        chk("midrst_ser_r", ser_r, 0);
        chk("midrst_ser_g", ser_g, 0);
        chk("midrst_ser_b", ser_b, 0);
        chk("midrst_ser_clk", ser_clk, 0);
        chk("midrst_phase", phase, 0);
        chk("midrst_ready", sym_ready, 0);
        chk("midrst_underrun", underrun, 0);
        #1 reset_n = 1'b1;
        #1;
        ph_ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cr[k] = ser_r; cc[k] = ser_clk; crdy[k] = sym_ready;
            if (phase != k[3:0]) ph_ok = 1'b0;
            if (k < 9) tick();
        end
        chk("post_rst_idle_r", cr, IDLE);
        chk("post_rst_clk", cc, CLKP);
        chk("post_rst_ready", crdy, 10'b10_0000_0000);
        chk("post_rst_phase_seq", ph_ok, 1'b1);
        tick();
        // primed was cleared by reset, so a missing symbol is not an underrun
        chk("post_rst_no_underrun", underrun, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
